dmem_ctrl: RTL and testbench

Parametrised successor to the single-cycle data memory. Word-organised RV32 data RAM with a valid/ready request port, sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) selected by funct3, and byte-lane write enables. Loads return one cycle after acceptance, and illegal accesses are flagged. A hardware clear sequencer zeroes the array after reset or on request. Sits between the core's MEM stage and the RAM array.

---
 rtl/dmem_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Word-organised RV32 data RAM behind a valid/ready request port. Supports
// LB/LH/LW/LBU/LHU loads and SB/SH/SW stores selected by funct3, with byte-lane
// write enables. Loads return one cycle after acceptance. Misaligned,
// out-of-range and illegal-funct3 accesses are flagged. A clear sequencer
// zeroes the whole array after reset or when clear_req is pulsed.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   clear_req   one-cycle pulse that starts a full-array clear sweep
//   init_done   array cleared and requests are being accepted
//   req_valid   request present
//   req_ready   block accepts a request this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  RV32 funct3 (width / signedness)
//   req_addr    byte address
//   req_wdata   store data, LSB-aligned
//   resp_valid  response for the request accepted in the previous cycle
//   resp_rdata  extended load result; 0 for stores and errors
//   resp_err    access was misaligned, out of range or used an illegal funct3
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          RANGE_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // First byte address past the array; one extra bit so DEPTH*4 always fits.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 4);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Access helpers
  // ---------------------------------------------------------------------------

  // funct3 legality: loads allow 000/001/010/100/101, stores only 000/001/010.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = we;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Alignment check keyed on the size field f3[1:0].
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lane[0];
      2'b10:   bad = |lane;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Byte-lane write mask for a store of the given size at the given lane.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the LSB-aligned store data across lanes; the mask picks the lanes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      2'b10:   d = wd;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Select the addressed byte/half from a word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h00_0000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_r [DEPTH];
  state_e           state_r;
  state_e           state_nx_s;
  logic [IDX_W-1:0] clr_idx_r;
  logic [IDX_W-1:0] clr_idx_nx_s;
  logic             ready_s;
  logic             done_s;

  logic             resp_valid_r;
  logic             resp_err_r;
  logic [31:0]      resp_rdata_r;

  logic [IDX_W-1:0] word_idx_s;
  logic [1:0]       lane_s;
  logic             oor_s;
  logic             err_s;
  logic             accept_s;
  logic             wr_en_s;
  logic [3:0]       wr_mask_s;
  logic [31:0]      wr_data_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      load_val_s;

  // Out-of-range decode; with the check disabled the index simply wraps.
  always_comb begin
    if (RANGE_CHECK) begin
      oor_s = ({1'b0, req_addr} >= ADDR_LIMIT);
    end else begin
      oor_s = 1'b0;
    end
  end

  assign word_idx_s = req_addr[IDX_W+1:2];
  assign lane_s     = req_addr[1:0];
  assign err_s      = funct3_illegal(req_we, req_funct3)
                    | misaligned(req_funct3, lane_s)
                    | oor_s;
  assign accept_s   = req_valid & ready_s;
  assign wr_en_s    = accept_s & req_we & ~err_s;
  assign wr_mask_s  = lane_mask(req_funct3, lane_s);
  assign wr_data_s  = store_data(req_funct3, req_wdata);
  assign rd_word_s  = mem_r[word_idx_s];
  assign load_val_s = load_extend(rd_word_s, lane_s, req_funct3);

  // FSM state and clear-index register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= {IDX_W{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      clr_idx_r <= clr_idx_nx_s;
    end
  end

  // FSM next state; ready/done drop in the same cycle clear_req is seen in
  // IDLE so no request can slip in ahead of the sweep.
  always_comb begin
    state_nx_s   = state_r;
    clr_idx_nx_s = clr_idx_r;
    ready_s      = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        if (clr_idx_r == IDX_LAST) begin
          state_nx_s   = ST_IDLE;
          clr_idx_nx_s = {IDX_W{1'b0}};
        end else begin
          clr_idx_nx_s = clr_idx_r + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_nx_s   = ST_CLEAR;
          clr_idx_nx_s = {IDX_W{1'b0}};
        end else begin
          ready_s = 1'b1;
          done_s  = 1'b1;
        end
      end
      default: begin
        state_nx_s   = ST_CLEAR;
        clr_idx_nx_s = {IDX_W{1'b0}};
      end
    endcase
  end

  // Array write port: sweep zeroes one word per cycle, otherwise masked stores.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_idx_r] <= 32'h0000_0000;
    end else if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask_s[b]) begin
          mem_r[word_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  // Response register: one response per accepted request, zero otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      resp_valid_r <= accept_s;
      resp_err_r   <= accept_s & err_s;
      if (accept_s && !err_s && !req_we) begin
        resp_rdata_r <= load_val_s;
      end else begin
        resp_rdata_r <= 32'h0000_0000;
      end
    end
  end

  assign req_ready  = ready_s;
  assign init_done  = done_s;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Directed bench for dmem_ctrl (DEPTH=64, ADDR_W=32, RANGE_CHECK=1). A table of
// back-to-back requests with hand-computed responses, plus sequences for the
// reset sweep, clear_req handling and asynchronous reset mid-request/mid-sweep.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  logic        clk;
  logic        reset_n;
  logic        clear_req;
  logic        init_done;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total;
  int bad;

  dmem_ctrl #(
    .DEPTH      (64),
    .ADDR_W     (32),
    .RANGE_CHECK(1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  // Counts edges until req_ready rises (bounded); optionally pulses clear_req
  // at a given count to show it is ignored mid-sweep.
  task automatic count_sweep(input int pulse_at, output int cyc, output logic saw_resp);
    cyc      = 0;
    saw_resp = 1'b0;
    while (!req_ready && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (resp_valid) saw_resp = 1'b1;
      clear_req = (cyc == pulse_at);
    end
    clear_req = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic saw;

    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h8000_80F0, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0010, 32'h0,         1'b0, 32'hFFFF_FFF0};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0011, 32'h0,         1'b0, 32'h0000_0080};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_8000};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_80F0};
    vecs[5]  = '{1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b1, 3'b000, 32'h0000_0022, 32'h0000_00AA, 1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b1, 3'b001, 32'h0000_0020, 32'h0000_BEEF, 1'b0, 32'h0000_0000};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_0020, 32'h0,         1'b0, 32'h11AA_BEEF};
    vecs[9]  = '{1'b0, 3'b010, 32'h0000_0022, 32'h0,         1'b1, 32'h0000_0000};
    vecs[10] = '{1'b0, 3'b001, 32'h0000_0013, 32'h0,         1'b1, 32'h0000_0000};
    vecs[11] = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    vecs[12] = '{1'b0, 3'b011, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_0000};
    vecs[13] = '{1'b1, 3'b100, 32'h0000_0024, 32'h5555_5555, 1'b1, 32'h0000_0000};
    vecs[14] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0,         1'b0, 32'h11AA_BEEF};
    vecs[15] = '{1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0000};
    vecs[16] = '{1'b0, 3'b010, 32'h0000_0024, 32'h0,         1'b0, 32'h0000_0000};
    vecs[17] = '{1'b0, 3'b000, 32'h0000_0023, 32'h0,         1'b0, 32'h0000_0011};
    vecs[18] = '{1'b0, 3'b001, 32'h0000_0021, 32'h0,         1'b1, 32'h0000_0000};
    vecs[19] = '{1'b1, 3'b000, 32'h0000_00FF, 32'h0000_007F, 1'b0, 32'h0000_0000};
    vecs[20] = '{1'b0, 3'b000, 32'h0000_00FF, 32'h0,         1'b0, 32'h0000_007F};
    vecs[21] = '{1'b0, 3'b010, 32'h0000_00FC, 32'h0,         1'b0, 32'h7F00_0000};
    vecs[22] = '{1'b0, 3'b110, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_0000};
    vecs[23] = '{1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
    vecs[24] = '{1'b1, 3'b001, 32'h0000_001E, 32'hFFFF_8001, 1'b0, 32'h0000_0000};
    vecs[25] = '{1'b0, 3'b010, 32'h0000_001C, 32'h0,         1'b0, 32'h8001_0000};

    // ---- reset state and power-up sweep with a load held valid ----
    reset_n   = 1'b0;
    clear_req = 1'b0;
    drive(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",      req_ready,  32'h0);
    chk("rst_init_done",  init_done,  32'h0);
    chk("rst_resp_valid", resp_valid, 32'h0);
    chk("rst_resp_err",   resp_err,   32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    #2;
    reset_n = 1'b1;
    count_sweep(-1, cyc, saw);
    chk("init_sweep_cycles", cyc,       32'd64);
    chk("init_sweep_noresp", saw,       32'h0);
    chk("init_done_up",      init_done, 32'h1);
    for (int w = 0; w < 64; w++) begin
      req_addr = 32'(w * 4);
      @(posedge clk);
      #1;
      chk($sformatf("zero_valid_%0d", w), resp_valid, 32'h1);
      chk($sformatf("zero_rdata_%0d", w), resp_rdata, 32'h0);
    end

    // ---- table of back-to-back requests ----
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("vec%0d_ready", i), req_ready, 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), resp_valid, 32'h1);
      chk($sformatf("vec%0d_err", i),   resp_err,   {31'h0, vecs[i].err});
      chk($sformatf("vec%0d_rdata", i), resp_rdata, vecs[i].rdata);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid", resp_valid, 32'h0);
    chk("idle_err",   resp_err,   32'h0);
    chk("idle_rdata", resp_rdata, 32'h0);

    // ---- clear_req with a load presented in the same cycle ----
    drive(1'b1, 3'b010, 32'h0000_0040, 32'h5A5A_5A5A);
    @(posedge clk);
    #1;
    chk("clr_store_valid", resp_valid, 32'h1);
    req_we    = 1'b0;
    clear_req = 1'b1;
    #1;
    chk("clr_ready_low",   req_ready,  32'h0);
    chk("clr_done_low",    init_done,  32'h0);
    chk("clr_prev_resp",   resp_valid, 32'h1);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    chk("clr_load_dropped", resp_valid, 32'h0);
    count_sweep(10, cyc, saw);
    chk("clr_sweep_cycles", cyc, 32'd64);
    chk("clr_sweep_noresp", saw, 32'h0);
    @(posedge clk);
    #1;
    chk("clr_load_valid", resp_valid, 32'h1);
    chk("clr_load_rdata", resp_rdata, 32'h0);
    req_addr = 32'h0000_0020;
    @(posedge clk);
    #1;
    chk("clr_load20_rdata", resp_rdata, 32'h0);

    // ---- asynchronous reset with a load response in flight ----
    drive(1'b1, 3'b010, 32'h0000_0008, 32'h1234_5678);
    @(posedge clk);
    #1;
    req_we = 1'b0;
    @(posedge clk);
    #1;
    chk("inflight_rdata", resp_rdata, 32'h1234_5678);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_valid", resp_valid, 32'h0);
    chk("async_rdata", resp_rdata, 32'h0);
    chk("async_ready", req_ready,  32'h0);
    chk("async_done",  init_done,  32'h0);
    #1;
    reset_n = 1'b1;
    count_sweep(-1, cyc, saw);
    chk("rst_req_sweep_cycles", cyc, 32'd64);
    @(posedge clk);
    #1;
    chk("rst_req_load_rdata", resp_rdata, 32'h0);

    // ---- reset pulsed 30 cycles into a sweep ----
    req_valid = 1'b0;
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_sweep_ready", req_ready, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_sweep_rst_done", init_done, 32'h0);
    #1;
    reset_n = 1'b1;
    count_sweep(-1, cyc, saw);
    chk("mid_sweep_restart_cycles", cyc, 32'd64);
    chk("mid_sweep_done", init_done, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
